// File: rtl/parity_frame_engine.sv
// Streaming frame parity generator/checker: accumulates even/odd parity over a
// multi-word frame, checks it against a received bit and keeps an error count.
module parity_frame_engine #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             odd_mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             in_par,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_par,
    output logic             out_err,
    output logic [CNT_W-1:0] err_count,
    input  logic             clr_count
);

    typedef enum logic [0:0] {StIdle, StAccum} state_e;

    state_e            state_q, state_d;
    logic              acc_q, acc_d;
    logic              mode_q, mode_d;
    logic              out_valid_q, out_valid_d;
    logic              out_par_q, out_par_d;
    logic              out_err_q, out_err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic accept;
    logic wp;
    logic frame_mode;
    logic data_par;
    logic base;
    logic mismatch;

    // State register (plus datapath registers sharing the same reset)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            acc_q       <= 1'b0;
            mode_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_par_q   <= 1'b0;
            out_err_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
            out_par_q   <= out_par_d;
            out_err_q   <= out_err_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = in_last ? StIdle : StAccum;
        end
    end

    // Output logic
    always_comb begin
        in_ready = ~out_valid_q | out_ready;
    end

    assign accept     = in_valid & in_ready;
    assign wp         = ^in_data;
    // acc holds the data-only parity; the latched mode is folded in at frame end,
    // which is equivalent to seeding the accumulator with the mode bit.
    assign frame_mode = (state_q == StIdle) ? odd_mode : mode_q;
    assign data_par   = (state_q == StIdle) ? wp : (acc_q ^ wp);
    assign base       = frame_mode ^ data_par;
    assign mismatch   = base ^ in_par;

    always_comb begin
        acc_d       = acc_q;
        mode_d      = mode_q;
        out_valid_d = out_valid_q;
        out_par_d   = out_par_q;
        out_err_d   = out_err_q;
        cnt_d       = cnt_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            if (state_q == StIdle) begin
                mode_d = odd_mode;
            end
            if (!in_last) begin
                acc_d = data_par;
            end else begin
                out_valid_d = 1'b1;
                out_par_d   = base;
                out_err_d   = mismatch;
                if (mismatch && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end

        if (clr_count) begin
            cnt_d = '0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_par   = out_par_q;
    assign out_err   = out_err_q;
    assign err_count = cnt_q;

endmodule

// File: tb/tb_parity_frame_engine.sv
// Directed scoreboard bench for parity_frame_engine: expected results are queued
// at stimulus time and checked by an independent monitor on each output handshake.
module tb_parity_frame_engine;

    localparam int unsigned WIDTH = 12;
    localparam int unsigned CNT_W = 2;

    logic             clk;
    logic             rst_n;
    logic             odd_mode;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             in_par;
    logic             out_valid;
    logic             out_ready;
    logic             out_par;
    logic             out_err;
    logic [CNT_W-1:0] err_count;
    logic             clr_count;

    typedef struct packed {
        logic             par;
        logic             err;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    parity_frame_engine #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .odd_mode (odd_mode),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_par   (in_par),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_par  (out_par),
        .out_err  (out_err),
        .err_count(err_count),
        .clr_count(clr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    // Monitor: a result is consumed on every cycle where out_valid & out_ready
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_cmp = n_cmp + 1;
            if (exp_q.size() == 0) begin
                n_bad = n_bad + 1;
                $display("FAIL unexpected_result: got par=%0b err=%0b cnt=%0d, none expected",
                         out_par, out_err, err_count);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (out_par !== e.par || out_err !== e.err || err_count !== e.cnt) begin
                    n_bad = n_bad + 1;
                    $display("FAIL result: got par=%0b err=%0b cnt=%0d, want par=%0b err=%0b cnt=%0d",
                             out_par, out_err, err_count, e.par, e.err, e.cnt);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp = n_cmp + 1;
        if (got !== want) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    // Present one beat and hold it until accepted; returns #1 after the accepting edge.
    task automatic beat(input logic [WIDTH-1:0] d, input logic last, input logic par,
                        input logic mode);
        logic ok;
        int   tries;
        odd_mode = mode;
        in_data  = d;
        in_last  = last;
        in_par   = par;
        in_valid = 1'b1;
        ok       = 1'b0;
        tries    = 0;
        while (!ok && tries < 20) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            tries++;
        end
        if (!ok) begin
            n_cmp = n_cmp + 1;
            n_bad = n_bad + 1;
            $display("FAIL accept_timeout: beat %0h never accepted", d);
        end
        in_valid = 1'b0;
    endtask

    task automatic expect_res(input logic par, input logic err, input logic [CNT_W-1:0] cnt);
        exp_t e;
        e.par = par;
        e.err = err;
        e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (exp_q.size() != 0) begin
            n_cmp = n_cmp + 1;
            n_bad = n_bad + 1;
            $display("FAIL drain_timeout: %0d results outstanding", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        odd_mode  = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        in_par    = 1'b0;
        out_ready = 1'b1;
        clr_count = 1'b0;

        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_par", 32'(out_par), 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Even single-beat frames, back to back
        expect_res(1'b0, 1'b0, 2'd0); beat(12'h000, 1'b1, 1'b0, 1'b0);
        expect_res(1'b1, 1'b0, 2'd0); beat(12'h001, 1'b1, 1'b1, 1'b0);
        expect_res(1'b1, 1'b0, 2'd0); beat(12'h002, 1'b1, 1'b1, 1'b0);
        expect_res(1'b0, 1'b0, 2'd0); beat(12'h003, 1'b1, 1'b0, 1'b0);
        drain();

        // Odd 3-beat frame: data parity 1^1^0=0, so odd parity is 1
        beat(12'h001, 1'b0, 1'b0, 1'b1);
        beat(12'h800, 1'b0, 1'b0, 1'b1);
        expect_res(1'b1, 1'b0, 2'd0);
        beat(12'h0FF, 1'b1, 1'b1, 1'b1);
        drain();
        // Same frame with odd_mode dropped mid-frame: result unchanged
        beat(12'h001, 1'b0, 1'b0, 1'b1);
        beat(12'h800, 1'b0, 1'b0, 1'b0);
        expect_res(1'b1, 1'b0, 2'd0);
        beat(12'h0FF, 1'b1, 1'b1, 1'b0);
        drain();

        // Backpressure: hold result A for 3 cycles while frame B waits
        out_ready = 1'b0;
        expect_res(1'b1, 1'b0, 2'd0);
        beat(12'h007, 1'b1, 1'b1, 1'b0);
        in_data  = 12'h00F;
        in_last  = 1'b1;
        in_par   = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out_par", 32'(out_par), 32'd1);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        expect_res(1'b0, 1'b0, 2'd0);
        beat(12'h00F, 1'b1, 1'b0, 1'b0);
        drain();

        // Saturating error count with CNT_W=2
        expect_res(1'b1, 1'b1, 2'd1); beat(12'h001, 1'b1, 1'b0, 1'b0);
        expect_res(1'b1, 1'b1, 2'd2); beat(12'h001, 1'b1, 1'b0, 1'b0);
        expect_res(1'b1, 1'b1, 2'd3); beat(12'h001, 1'b1, 1'b0, 1'b0);
        expect_res(1'b1, 1'b1, 2'd3); beat(12'h001, 1'b1, 1'b0, 1'b0);
        expect_res(1'b1, 1'b1, 2'd3); beat(12'h001, 1'b1, 1'b0, 1'b0);
        drain();

        // Reset after 2 of 4 beats of an odd frame
        beat(12'h001, 1'b0, 1'b0, 1'b1);
        beat(12'h003, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_err_count", 32'(err_count), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        expect_res(1'b1, 1'b0, 2'd0);
        beat(12'h001, 1'b1, 1'b1, 1'b0);
        drain();

        // clr_count wins over a simultaneous increment
        expect_res(1'b1, 1'b1, 2'd1);
        beat(12'h001, 1'b1, 1'b0, 1'b0);
        expect_res(1'b1, 1'b1, 2'd0);
        clr_count = 1'b1;
        beat(12'h001, 1'b1, 1'b0, 1'b0);
        clr_count = 1'b0;
        drain();

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
